// File: rtl/uart_boot_loader.sv
// uart_boot_loader: turns a framed UART byte stream into 32-bit instruction-memory writes, then releases the core.
// Latency: the write strobe comes one cycle after the 4th byte of a word; the core is released after the checksum byte (or after the last write).
// Backpressure: none; one byte per cycle is sustained. The checksum byte and CSUM state exist only when BOOT_CHECKSUM_EN is defined.
module uart_boot_loader #(
    parameter int         ADDR_WIDTH     = 6,
    parameter int         DATA_WIDTH     = 32,
    parameter logic [7:0] HEADER         = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 500000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  core_rst_n,
    output logic                  boot_busy,
    output logic                  boot_err,
    output logic [ADDR_WIDTH:0]   words_loaded
);
    localparam int                  MAX_WORDS = 1 << ADDR_WIDTH;
    localparam int                  TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0]    TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0]    TMO_ONE   = TMO_W'(1);
    localparam logic [ADDR_WIDTH:0] WORD_ONE  = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [2:0] {S_IDLE, S_COUNT, S_DATA, S_CSUM, S_RUN, S_ERR} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
    logic [ADDR_WIDTH:0]     words_q, words_d;
    logic [1:0]              idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    core_rst_n_q, core_rst_n_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;
    logic                    in_frame;
    logic                    data_done;

`ifdef BOOT_CHECKSUM_EN
    logic [7:0]              csum_q, csum_d;
    // The frame always ends in CSUM, so DATA never finishes on its own.
    assign data_done = 1'b0;
`else
    // Without a checksum, DATA lingers for the write cycle of the last word, then releases the core.
    assign data_done = (words_q == cnt_q);
`endif

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        words_d   = words_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        tmo_d     = '0;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        in_frame  = (state_q == S_COUNT) || (state_q == S_DATA) || (state_q == S_CSUM);
`ifdef BOOT_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        // Inter-byte gap counter only runs inside a frame.
        if (in_frame && !rx_valid) begin
            tmo_d = tmo_q + TMO_ONE;
        end

        unique case (state_q)
            S_IDLE, S_ERR: begin
                if (rx_valid && rx_data == HEADER) begin
                    state_d = S_COUNT;
                    words_d = '0;
                end
            end
            S_COUNT: begin
                if (rx_valid) begin
                    if (rx_data == 8'd0 || int'(rx_data) > MAX_WORDS) begin
                        state_d = S_ERR;
                    end else begin
                        cnt_d   = (ADDR_WIDTH + 1)'(rx_data);
                        idx_d   = '0;
                        state_d = S_DATA;
`ifdef BOOT_CHECKSUM_EN
                        csum_d  = '0;
`endif
                    end
                end
            end
            S_DATA: begin
                if (data_done) begin
                    state_d = S_RUN;
                end else if (rx_valid) begin
                    // Little-endian: the first byte ends up in bits 7:0.
                    shift_d = {rx_data, shift_q[DATA_WIDTH-1:8]};
                    idx_d   = idx_q + 2'd1;
`ifdef BOOT_CHECKSUM_EN
                    csum_d  = csum_q + rx_data;
`endif
                    if (idx_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = words_q[ADDR_WIDTH-1:0];
                        wdata_d = shift_d;
                        words_d = words_q + WORD_ONE;
`ifdef BOOT_CHECKSUM_EN
                        if (words_d == cnt_q) begin
                            state_d = S_CSUM;
                        end
`endif
                    end
                end
            end
            S_CSUM: begin
`ifdef BOOT_CHECKSUM_EN
                if (rx_valid) begin
                    state_d = (rx_data == csum_q) ? S_RUN : S_ERR;
                end
`else
                state_d = S_ERR;
`endif
            end
            S_RUN: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A byte arriving on the expiry cycle wins over the timeout.
        if (in_frame && !rx_valid && !data_done && tmo_q == TMO_LAST) begin
            state_d = S_ERR;
        end

        core_rst_n_d = (state_d == S_RUN);
        busy_d       = (state_d == S_COUNT) || (state_d == S_DATA) || (state_d == S_CSUM);
        err_d        = (state_d == S_ERR);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            words_q      <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            tmo_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            core_rst_n_q <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            words_q      <= words_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            tmo_q        <= tmo_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            core_rst_n_q <= core_rst_n_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

`ifdef BOOT_CHECKSUM_EN
    // Running checksum of the data bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign core_rst_n   = core_rst_n_q;
    assign boot_busy    = busy_q;
    assign boot_err     = err_q;
    assign words_loaded = words_q;

endmodule

// File: doc/uart_boot_loader.md
# uart_boot_loader

Upstream loader for the pipelined RISC-V core. It takes a byte stream from the UART receiver and writes a program frame into the instruction memory, one 32-bit word at a time. The core is held in reset until a complete, valid frame has been written. Once the core is released, the loader ignores all UART traffic until `rst_n` is asserted again.

## Interface
Parameters:
- `ADDR_WIDTH`, 6: word-address width of the instruction memory; capacity is 2^ADDR_WIDTH words.
- `DATA_WIDTH`, 32: instruction word width. Fixed at 4 bytes.
- `HEADER`, 8'hA5: frame start byte.
- `TIMEOUT_CYCLES`, 500000: maximum allowed clock cycles between consecutive bytes inside a frame.

Ports:
- `clk` input 1: single clock. All logic is rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `rx_data` input 8: received byte. Valid only when `rx_valid`=1.
- `rx_valid` input 1: one-cycle strobe per received byte. Back-to-back strobes are legal.
- `imem_we` output 1: instruction-memory write strobe, one cycle per word.
- `imem_addr` output ADDR_WIDTH: word address of the current write.
- `imem_wdata` output DATA_WIDTH: assembled word.
- `core_rst_n` output 1: core reset. 0 = core held in reset.
- `boot_busy` output 1: 1 while a frame is in progress (states COUNT, DATA, CSUM).
- `boot_err` output 1: sticky frame-error flag.
- `words_loaded` output ADDR_WIDTH+1: number of words written in the current frame.

## Operation
Frame format: `HEADER`, count byte N, then N words of 4 bytes each (little-endian, byte 0 = bits 7:0), then one checksum byte.
- Checksum = 8-bit wrapping sum of all 4N data bytes. The header and count bytes are not included.

State machine:
- **IDLE**: ignore every byte except `HEADER`. On `HEADER`: go to COUNT, clear `words_loaded`.
- **COUNT**:
  - N = 0 or N > 2^ADDR_WIDTH: go to ERR.
  - Otherwise: latch N, clear the checksum accumulator, clear the byte index, go to DATA.
- **DATA**:
  - Shift each byte into the word register and add it to the checksum.
  - On the 4th byte: issue a write, increment `words_loaded`.
  - After word N-1 is written: go to CSUM.
- **CSUM**:
  - Received byte equals the accumulated sum: go to RUN.
  - Otherwise: go to ERR.
- **RUN**: `core_rst_n`=1. All bytes are ignored. Only `rst_n` leaves this state.
- **ERR**: `boot_err`=1, `core_rst_n`=0.
  - `HEADER` received: clear `boot_err` and go to COUNT.
  - Any other byte: ignored.
- **Timeout**: an inter-byte counter resets on every `rx_valid`. In COUNT, DATA or CSUM, reaching `TIMEOUT_CYCLES` with no byte goes to ERR. The counter is idle in all other states.
- **Write addressing**: `imem_addr` = index of the word within the frame, starting at 0.
- **Error handling**: words already written before an error are left in memory. They are not rewritten.

## Timing
- **Reset values**:
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
  - `core_rst_n`=0, `boot_busy`=0, `boot_err`=0, `words_loaded`=0.
  - State = IDLE.
- **Reset mid-frame**: asynchronous. All outputs take their reset values immediately, including during DATA or RUN.
- **Byte acceptance**: a byte is accepted on the rising edge where `rx_valid`=1.
- **Write timing**: all outputs are registered.
  - If the 4th byte of a word is accepted at edge E, then `imem_we`=1 for exactly the cycle after E, with stable `imem_addr` and `imem_wdata`.
  - `words_loaded` increments at that same edge E.
- **Core release**: if the correct checksum byte is accepted at edge E, `core_rst_n` rises after E and stays high.
- **Error flag**: `boot_err` rises the cycle after the erroneous byte is accepted, or the cycle after the timeout expires.
- **Throughput**: one byte per cycle is sustained without loss. No backpressure exists.
- **Simultaneous events**: a byte arriving in the same cycle the timeout expires counts as the byte; the timeout does not fire.

## Configuration
- **`BOOT_CHECKSUM_EN` defined**: frame ends with the checksum byte and the CSUM state exists, as described above.
- **`BOOT_CHECKSUM_EN` undefined**:
  - No checksum byte is expected and the accumulator is removed.
  - After the last word's write, the FSM goes straight to RUN; `core_rst_n` rises in the cycle after the `imem_we` cycle.
  - ERR is reachable only through a bad count or a timeout.

## Test plan
1. **Single-word frame**: send A5,01,13,00,00,00,13. Expect one `imem_we` pulse with addr 0 and wdata 0x00000013, `words_loaded`=1, `core_rst_n`=1 one cycle after the last byte, `boot_err`=0.
2. **Bad checksum, then recovery**: send the same frame with checksum 14. Expect the write at addr 0 still occurs, `boot_err`=1, and `core_rst_n` stays 0. Then resend the valid frame: `boot_err` clears on A5 and the core is released.
3. **Count out of range** (ADDR_WIDTH=6): send A5,41. Expect ERR with no `imem_we`. Send A5,00: same result.
4. **Timeout** (TIMEOUT_CYCLES=16): send A5,02 and 3 data bytes, then idle. Expect `boot_err`=1 after 16 idle cycles with no `imem_we`. Repeat with a byte arriving on the 16th cycle: no error.
5. **Garbage and traffic after RUN**: send 00,FF, then a valid 2-word frame back-to-back at one byte per cycle. Expect writes at addr 0 and 1 in order, then release. Bytes sent afterwards cause no `imem_we` and no state change.
6. **Reset mid-frame**: assert `rst_n` low during DATA. Expect all outputs at reset values asynchronously. After reset is released, a fresh frame loads correctly.
